execute_stage: RTL and testbench
================================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 clock  in  1  single clock; all state updates on its rising edge.
REQ-002 reset  in  1  asynchronous, active-low reset.
REQ-003 enable_execute  in  1  capture strobe; stage advances only when 1.
REQ-004 E_Control  in  6  {alu_control[5:4], pcselect1[3:2], pcselect2[1], op2select[0]} from decode.
REQ-005 Mem_Control_in  in  1 / W_Control_in  in  2  decode control, forwarded.
REQ-006 IR  in  16 / npc_in  in  16  decoded instruction and next PC.
REQ-007 VSR1, VSR2  in  16  register-file read values for sr1/sr2.
REQ-008 bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2  in  1  operand forwarding selects; Mem_Bypass_Val  in  16  memory-stage forward value.
REQ-009 aluout  out  16 / pcout  out  16  ALU result and computed address.
REQ-010 W_Control_out  out  2 / Mem_Control_out  out  1 / M_Data  out  16  registered controls and store data.
REQ-011 dr  out  3 / sr1  out  3 / sr2  out  3 / IR_Exec  out  16 / NZP  out  3 / ex_valid  out  1.

Function
REQ-012 sr1 SHALL equal IR[8:6]; sr2 SHALL equal IR[11:9] when IR[15:12] is ST(0011), STR(0111), STI(1011), else IR[2:0]; both combinational.
REQ-013 Operand A SHALL be, by priority: aluout if bypass_alu_1, Mem_Bypass_Val if bypass_mem_1, else VSR1; operand B likewise with *_2 and VSR2.
REQ-014 op2select=1 SHALL select operand B as ALU op2; 0 SHALL select sign-extended IR[4:0].
REQ-015 alu_control 00 ADD (mod 2^16, carry discarded), 01 AND, 10 NOT of operand A, 11 pass operand A.
REQ-016 pcselect1 00 sext IR[10:0], 01 sext IR[8:0], 10 sext IR[5:0], 11 zero; pcselect2=1 base npc_in, 0 base operand A; pcout = base + offset, mod 2^16.
REQ-017 LEA(1110) SHALL load aluout with the address computed per REQ-016 instead of the ALU result.
REQ-018 NZP SHALL be IR[11:9] for BR(0000), 3'b111 for JMP(1100), 3'b000 otherwise.
REQ-019 On a rising edge with enable_execute=1: aluout, pcout, W_Control_out, Mem_Control_out, M_Data (operand B), dr (IR[11:9]), IR_Exec, NZP SHALL register; latency 1 cycle.
REQ-020 With enable_execute=0 all registered outputs SHALL hold; NZP SHALL be cleared to 000 so no branch is re-taken.
REQ-021 ex_valid SHALL equal enable_execute delayed one cycle.
REQ-022 bypass_alu_x and bypass_mem_x both 1 SHALL resolve to the ALU path.
REQ-023 bypass_alu_x feeds back the currently registered aluout (pre-update) within the same cycle.

Reset
REQ-024 While reset=0 all registered outputs, including ex_valid and NZP, SHALL be 0 immediately, independent of clock.
REQ-025 Reset asserted mid-operation SHALL discard the in-flight instruction; first capture after release needs enable_execute=1.

Configuration
REQ-026 Macro EXECUTE_BYPASS_EN defined: forwarding per REQ-013/022/023 compiled in.
REQ-027 EXECUTE_BYPASS_EN undefined: bypass_* and Mem_Bypass_Val ignored; operand A = VSR1, operand B = VSR2; ports remain present.

Verification
REQ-028 ADD: IR=16'h1042, E_Control=6'b000001, VSR1=5, VSR2=7, enable=1 -> next cycle aluout=12, dr=0, ex_valid=1.
REQ-029 ADD imm: IR=16'h1263 (imm 3), op2select=0, VSR1=16'hFFFF -> aluout=16'h0002 (wrap).
REQ-030 BR: IR=16'h0E05, pcselect1=01, pcselect2=1, npc_in=16'h3001 -> pcout=16'h3006, NZP=111; next cycle enable=0 -> NZP=000, pcout holds.
REQ-031 Bypass (EXECUTE_BYPASS_EN defined): aluout=9, bypass_alu_1=1, bypass_mem_1=1, Mem_Bypass_Val=4, VSR2=1, ADD -> aluout=10; macro undefined, VSR1=0 -> aluout=1.
REQ-032 Store: IR=16'h7842 (STR), sr2=4, VSR2=16'hABCD -> M_Data=16'hABCD, Mem_Control_out follows Mem_Control_in.
REQ-033 Reset pulse low mid-cycle after REQ-028 -> all outputs 0 asynchronously; held while enable_execute=0 after release.

Source files
------------

// File: rtl/execute_stage.sv
// execute_stage: ALU/address execute stage; define EXECUTE_BYPASS_EN to compile in operand forwarding
module execute_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_execute,
  input  logic [5:0]  E_Control,
  input  logic        Mem_Control_in,
  input  logic [1:0]  W_Control_in,
  input  logic [15:0] IR,
  input  logic [15:0] npc_in,
  input  logic [15:0] VSR1,
  input  logic [15:0] VSR2,
  input  logic        bypass_alu_1,
  input  logic        bypass_alu_2,
  input  logic        bypass_mem_1,
  input  logic        bypass_mem_2,
  input  logic [15:0] Mem_Bypass_Val,
  output logic [15:0] aluout,
  output logic [15:0] pcout,
  output logic [1:0]  W_Control_out,
  output logic        Mem_Control_out,
  output logic [15:0] M_Data,
  output logic [2:0]  dr,
  output logic [2:0]  sr1,
  output logic [2:0]  sr2,
  output logic [15:0] IR_Exec,
  output logic [2:0]  NZP,
  output logic        ex_valid
);
  logic [3:0]  opc;
  logic [15:0] op_a, op_b, op2, alu_res, offset, pc_addr, alu_next;
  logic [2:0]  nzp_next;
  assign opc = IR[15:12];
`ifndef EXECUTE_BYPASS_EN
  logic bypass_unused;
  assign bypass_unused = ^{bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, Mem_Bypass_Val};
`endif
  always_comb begin
    sr1 = IR[8:6];
    sr2 = (opc == 4'b0011 || opc == 4'b0111 || opc == 4'b1011) ? IR[11:9] : IR[2:0];
`ifdef EXECUTE_BYPASS_EN
    op_a = bypass_alu_1 ? aluout : bypass_mem_1 ? Mem_Bypass_Val : VSR1;
    op_b = bypass_alu_2 ? aluout : bypass_mem_2 ? Mem_Bypass_Val : VSR2;
`else
    op_a = VSR1;
    op_b = VSR2;
`endif
    op2 = E_Control[0] ? op_b : {{11{IR[4]}}, IR[4:0]};
    alu_res = E_Control[5:4] == 2'b00 ? op_a + op2 :
              E_Control[5:4] == 2'b01 ? op_a & op2 :
              E_Control[5:4] == 2'b10 ? ~op_a : op_a;
    offset = E_Control[3:2] == 2'b00 ? {{5{IR[10]}}, IR[10:0]} :
             E_Control[3:2] == 2'b01 ? {{7{IR[8]}}, IR[8:0]} :
             E_Control[3:2] == 2'b10 ? {{10{IR[5]}}, IR[5:0]} : 16'h0000;
    pc_addr = (E_Control[1] ? npc_in : op_a) + offset;
    alu_next = opc == 4'b1110 ? pc_addr : alu_res;
    nzp_next = opc == 4'b0000 ? IR[11:9] : opc == 4'b1100 ? 3'b111 : 3'b000;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      aluout          <= '0;
      pcout           <= '0;
      W_Control_out   <= '0;
      Mem_Control_out <= 1'b0;
      M_Data          <= '0;
      dr              <= '0;
      IR_Exec         <= '0;
      NZP             <= '0;
      ex_valid        <= 1'b0;
    end else begin
      ex_valid <= enable_execute;
      NZP      <= enable_execute ? nzp_next : 3'b000;
      if (enable_execute) begin
        aluout          <= alu_next;
        pcout           <= pc_addr;
        W_Control_out   <= W_Control_in;
        Mem_Control_out <= Mem_Control_in;
        M_Data          <= op_b;
        dr              <= IR[11:9];
        IR_Exec         <= IR;
      end
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed vectors against an arithmetic reference model of the execute stage
module tb_execute_stage;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable_execute = 1'b0;
  logic [5:0]  E_Control = '0;
  logic        Mem_Control_in = 1'b0;
  logic [1:0]  W_Control_in = '0;
  logic [15:0] IR = '0, npc_in = '0, VSR1 = '0, VSR2 = '0, Mem_Bypass_Val = '0;
  logic        bypass_alu_1 = 1'b0, bypass_alu_2 = 1'b0, bypass_mem_1 = 1'b0, bypass_mem_2 = 1'b0;
  logic [15:0] aluout, pcout, M_Data, IR_Exec;
  logic [1:0]  W_Control_out;
  logic        Mem_Control_out, ex_valid;
  logic [2:0]  dr, sr1, sr2, NZP;
  int checks = 0;
  int errors = 0;

  execute_stage dut (
    .clock(clock), .reset(reset), .enable_execute(enable_execute), .E_Control(E_Control),
    .Mem_Control_in(Mem_Control_in), .W_Control_in(W_Control_in), .IR(IR), .npc_in(npc_in),
    .VSR1(VSR1), .VSR2(VSR2), .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
    .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2), .Mem_Bypass_Val(Mem_Bypass_Val),
    .aluout(aluout), .pcout(pcout), .W_Control_out(W_Control_out), .Mem_Control_out(Mem_Control_out),
    .M_Data(M_Data), .dr(dr), .sr1(sr1), .sr2(sr2), .IR_Exec(IR_Exec), .NZP(NZP), .ex_valid(ex_valid)
  );

  always #5 clock = ~clock;

  // Reference model: expected register contents after each edge
  logic [15:0] m_alu = '0, m_pc = '0, m_mdata = '0, m_ir = '0;
  logic [1:0]  m_w = '0;
  logic        m_mem = 1'b0, m_ev = 1'b0;
  logic [2:0]  m_dr = '0, m_nzp = '0;

  function automatic logic [15:0] pick(input logic ba, input logic bm, input logic [15:0] prev, input logic [15:0] v);
`ifdef EXECUTE_BYPASS_EN
    if (ba) return prev;
    if (bm) return Mem_Bypass_Val;
`endif
    return v;
  endfunction

  function automatic logic [15:0] addr(input logic [15:0] a);
    int off;
    case (E_Control[3:2])
      2'd0: off = int'($signed(IR[10:0]));
      2'd1: off = int'($signed(IR[8:0]));
      2'd2: off = int'($signed(IR[5:0]));
      default: off = 0;
    endcase
    return 16'((E_Control[1] ? int'(npc_in) : int'(a)) + off);
  endfunction

  function automatic logic [15:0] result(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] y;
    y = E_Control[0] ? b : 16'(int'($signed(IR[4:0])));
    if (IR[15:12] == 4'd14) return addr(a);
    case (E_Control[5:4])
      2'd0: return 16'(int'(a) + int'(y));
      2'd1: return a & y;
      2'd2: return ~a;
      default: return a;
    endcase
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_alu <= '0; m_pc <= '0; m_mdata <= '0; m_ir <= '0; m_w <= '0;
      m_mem <= 1'b0; m_ev <= 1'b0; m_dr <= '0; m_nzp <= '0;
    end else begin
      m_ev  <= enable_execute;
      m_nzp <= !enable_execute ? 3'd0 : IR[15:12] == 4'd0 ? IR[11:9] : IR[15:12] == 4'd12 ? 3'd7 : 3'd0;
      if (enable_execute) begin
        m_alu   <= result(pick(bypass_alu_1, bypass_mem_1, m_alu, VSR1), pick(bypass_alu_2, bypass_mem_2, m_alu, VSR2));
        m_pc    <= addr(pick(bypass_alu_1, bypass_mem_1, m_alu, VSR1));
        m_mdata <= pick(bypass_alu_2, bypass_mem_2, m_alu, VSR2);
        m_ir <= IR; m_w <= W_Control_in; m_mem <= Mem_Control_in; m_dr <= IR[11:9];
      end
    end
  end

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    chk("aluout", aluout, m_alu);
    chk("pcout", pcout, m_pc);
    chk("M_Data", M_Data, m_mdata);
    chk("IR_Exec", IR_Exec, m_ir);
    chk("W_Control_out", 16'(W_Control_out), 16'(m_w));
    chk("Mem_Control_out", 16'(Mem_Control_out), 16'(m_mem));
    chk("dr", 16'(dr), 16'(m_dr));
    chk("NZP", 16'(NZP), 16'(m_nzp));
    chk("ex_valid", 16'(ex_valid), 16'(m_ev));
    chk("sr1", 16'(sr1), 16'(IR[8:6]));
    chk("sr2", 16'(sr2), 16'((IR[15:12] inside {4'd3, 4'd7, 4'd11}) ? IR[11:9] : IR[2:0]));
  end

  task automatic drive(input logic [15:0] ir, input logic [5:0] ec, input logic [15:0] v1, input logic [15:0] v2,
                       input logic [15:0] npc, input logic en);
    IR = ir; E_Control = ec; VSR1 = v1; VSR2 = v2; npc_in = npc; enable_execute = en;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1 reset = 1'b0;
    #2;
    chk("rst_aluout", aluout, 16'h0000);
    chk("rst_nzp", 16'(NZP), 16'h0000);
    chk("rst_ex_valid", 16'(ex_valid), 16'h0000);
    #9 reset = 1'b1;
    drive(16'h1042, 6'b000001, 16'd5, 16'd7, 16'h3000, 1'b1);
    chk("add_aluout", aluout, 16'd12);
    chk("add_model", m_alu, 16'd12);
    chk("add_dr", 16'(dr), 16'd0);
    chk("add_ex_valid", 16'(ex_valid), 16'd1);
    drive(16'h1263, 6'b000000, 16'hFFFF, 16'h0000, 16'h3000, 1'b1);
    chk("addimm_wrap", aluout, 16'h0002);
    chk("addimm_dr", 16'(dr), 16'd1);
    drive(16'h0E05, 6'b000110, 16'h0000, 16'h0000, 16'h3001, 1'b1);
    chk("br_pcout", pcout, 16'h3006);
    chk("br_nzp", 16'(NZP), 16'h0007);
    drive(16'h0E05, 6'b000110, 16'h0000, 16'h0000, 16'h4000, 1'b0);
    chk("hold_nzp", 16'(NZP), 16'h0000);
    chk("hold_pcout", pcout, 16'h3006);
    chk("hold_ex_valid", 16'(ex_valid), 16'h0000);
    drive(16'h1042, 6'b000001, 16'd4, 16'd5, 16'h0000, 1'b1);
    chk("pre_bypass", aluout, 16'd9);
    bypass_alu_1 = 1'b1; bypass_mem_1 = 1'b1; Mem_Bypass_Val = 16'd4;
    drive(16'h1042, 6'b000001, 16'd0, 16'd1, 16'h0000, 1'b1);
`ifdef EXECUTE_BYPASS_EN
    chk("bypass_alu_wins", aluout, 16'd10);
`else
    chk("bypass_ignored", aluout, 16'd1);
`endif
    bypass_alu_1 = 1'b0; bypass_mem_1 = 1'b0; bypass_mem_2 = 1'b1; Mem_Bypass_Val = 16'h0020;
    drive(16'h1042, 6'b000001, 16'd3, 16'd1, 16'h0000, 1'b1);
`ifdef EXECUTE_BYPASS_EN
    chk("bypass_mem2", aluout, 16'h0023);
`else
    chk("bypass_mem2_ignored", aluout, 16'h0004);
`endif
    bypass_mem_2 = 1'b0;
    Mem_Control_in = 1'b1; W_Control_in = 2'b10;
    drive(16'h7842, 6'b000001, 16'h0001, 16'hABCD, 16'h0000, 1'b1);
    chk("str_sr2", 16'(sr2), 16'd4);
    chk("str_mdata", M_Data, 16'hABCD);
    chk("str_memctl", 16'(Mem_Control_out), 16'd1);
    chk("str_wctl", 16'(W_Control_out), 16'd2);
    Mem_Control_in = 1'b0; W_Control_in = 2'b01;
    drive(16'h5042, 6'b010001, 16'hF0F0, 16'h3C3C, 16'h0000, 1'b1);
    chk("and", aluout, 16'h3030);
    drive(16'h9000, 6'b100000, 16'h00FF, 16'h0000, 16'h0000, 1'b1);
    chk("not", aluout, 16'hFF00);
    drive(16'h1000, 6'b110000, 16'h1234, 16'h0000, 16'h0000, 1'b1);
    chk("pass", aluout, 16'h1234);
    drive(16'hE003, 6'b000110, 16'h0000, 16'h0000, 16'h3000, 1'b1);
    chk("lea", aluout, 16'h3003);
    drive(16'h07FF, 6'b000010, 16'h0000, 16'h0000, 16'h3000, 1'b1);
    chk("br_negoff", pcout, 16'h2FFF);
    drive(16'hC0BE, 6'b001000, 16'h4000, 16'h0000, 16'h0000, 1'b1);
    chk("jmp_nzp", 16'(NZP), 16'd7);
    chk("jmp_base_a_off6", pcout, 16'h3FFE);
    drive(16'hC080, 6'b001100, 16'h4444, 16'h0000, 16'h0000, 1'b1);
    chk("zero_off", pcout, 16'h4444);
    drive(16'h1042, 6'b000001, 16'd5, 16'd7, 16'h3000, 1'b1);
    #3 reset = 1'b0;
    #1;
    chk("async_aluout", aluout, 16'h0000);
    chk("async_pcout", pcout, 16'h0000);
    chk("async_ex_valid", 16'(ex_valid), 16'h0000);
    chk("async_irexec", IR_Exec, 16'h0000);
    enable_execute = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("post_rst_hold", aluout, 16'h0000);
    chk("post_rst_valid", 16'(ex_valid), 16'h0000);
    drive(16'h1042, 6'b000001, 16'd5, 16'd7, 16'h3000, 1'b1);
    chk("post_rst_capture", aluout, 16'd12);
    @(negedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
